operand_fwd_reg: RTL
====================

Name: operand_fwd_reg

Overview:
- Parametrised successor to the 2:1 ALU operand-B select (GRF vs extended immediate).
- Selects the execute-stage operand from GRF data, extended immediate, or one of NFWD forwarding channels, then registers it into the ID/EX boundary.
- Detects unresolved RAW hazards and issues a stall request; supports downstream hold and flush.
- Sits between decode/GRF read and the ALU input latch of the pipelined CPU.

Parameters:
- WIDTH, 32, operand data width.
- AW, 5, register-address width.
- NFWD, 2, forwarding channels; channel 0 = youngest producer, highest priority.
- CW, 4, width of the saturating consecutive-bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  decode slot holds a real instruction.
- en  in  1  downstream advance; 0 = hold all state.
- flush  in  1  kill the registered slot.
- src_sel  in  1  0 = register source (GRF/forwarded), 1 = ext_data.
- rs_addr  in  AW  source register number.
- grf_data  in  WIDTH  GRF read data.
- ext_data  in  WIDTH  extended immediate.
- fwd_we  in  NFWD  channel i will write a register.
- fwd_rdy  in  NFWD  channel i data is valid this cycle.
- fwd_addr  in  NFWD*AW  channel i destination, slice [i*AW +: AW].
- fwd_data  in  NFWD*WIDTH  channel i result, slice [i*WIDTH +: WIDTH].
- stall_req  out  1  combinational; unresolved hazard, freeze upstream.
- op_out  out  WIDTH  registered operand.
- op_valid  out  1  registered; op_out is a real operand.
- fwd_hit  out  NFWD  registered one-hot; which channel supplied op_out, 0 if none.
- bubble_cnt  out  CW  registered consecutive hazard-bubble count, saturating.

Behaviour:
- Reset (reset=0, async): op_out=0, op_valid=0, fwd_hit=0, bubble_cnt=0. Held until reset returns to 1.
- Operand resolution (combinational):
  - src_sel=1: operand=ext_data, no hazard.
  - src_sel=0 and rs_addr=0: operand=grf_data (register 0 is never forwarded).
  - Otherwise scan i=0..NFWD-1. The first i with fwd_we[i]=1 and fwd_addr[i]==rs_addr is the match. Lower-index matches win; later matches are ignored even if ready.
  - Match with fwd_rdy[i]=1: operand=fwd_data[i], hit=one-hot i.
  - Match with fwd_rdy[i]=0: hazard.
  - No match: operand=grf_data.
- stall_req = in_valid & hazard & ~flush. Combinational, same cycle, no latency. It is also asserted while en=0.
- Register update priority at posedge clk:
  1. flush=1: op_valid=0, op_out=0, fwd_hit=0, bubble_cnt=0. Applies regardless of en.
  2. en=0: hold all registers.
  3. in_valid=1 and hazard: bubble. op_valid=0, op_out=0, fwd_hit=0, bubble_cnt=min(bubble_cnt+1, 2^CW-1).
  4. Otherwise: op_out=operand, op_valid=in_valid, fwd_hit=(in_valid ? hit : 0), bubble_cnt=0.
- Latency: one cycle from operand resolution to op_out.
- bubble_cnt saturates at 2^CW-1 and never wraps. It clears on any load or flush.
- Reset asserted mid-stall: all outputs return to reset values immediately. stall_req follows the inputs.

Test Plan:
- Reset: assert reset=0 mid-run with op_out=0x1234 → op_out, op_valid, fwd_hit and bubble_cnt all 0 before the next edge.
- Immediate path: src_sel=1, ext_data=0xFFFF8000, fwd channel 0 matching rs_addr → after one edge op_out=0xFFFF8000, fwd_hit=0, stall_req=0.
- Priority: rs_addr=8, ch0 (we=1, addr=8, rdy=1, data=0xAAAA), ch1 (addr=8, data=0xBBBB) → op_out=0xAAAA, fwd_hit=01.
- Register 0: rs_addr=0, ch0 addr=0 we=1 data=5, grf_data=0 → op_out=0, fwd_hit=0.
- Hazard/saturation: ch0 match with rdy=0 held 20 cycles, CW=4 → stall_req=1, op_valid=0 each cycle, bubble_cnt=15 and holds. Then rdy=1, data=0x77 → op_out=0x77, op_valid=1, bubble_cnt=0.
- Hold/flush: en=0 with new inputs → outputs unchanged. flush=1 together with en=0 → op_valid=0, op_out=0.

Source files
------------

// File: rtl/operand_fwd_reg_if.sv
// Decode-to-execute operand bus: the GRF/immediate/forwarding inputs and the registered operand outputs.
// The master modport is the decode side and the slave modport is the operand register.
interface operand_fwd_reg_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NFWD  = 2,
    parameter int CW    = 4
);
    logic                    in_valid;
    logic                    en;
    logic                    flush;
    logic                    src_sel;
    logic [AW-1:0]           rs_addr;
    logic [WIDTH-1:0]        grf_data;
    logic [WIDTH-1:0]        ext_data;
    logic [NFWD-1:0]         fwd_we;
    logic [NFWD-1:0]         fwd_rdy;
    logic [NFWD*AW-1:0]      fwd_addr;
    logic [NFWD*WIDTH-1:0]   fwd_data;
    logic                    stall_req;
    logic [WIDTH-1:0]        op_out;
    logic                    op_valid;
    logic [NFWD-1:0]         fwd_hit;
    logic [CW-1:0]           bubble_cnt;

    modport master (
        output in_valid, en, flush, src_sel, rs_addr, grf_data, ext_data,
               fwd_we, fwd_rdy, fwd_addr, fwd_data,
        input  stall_req, op_out, op_valid, fwd_hit, bubble_cnt
    );

    modport slave (
        input  in_valid, en, flush, src_sel, rs_addr, grf_data, ext_data,
               fwd_we, fwd_rdy, fwd_addr, fwd_data,
        output stall_req, op_out, op_valid, fwd_hit, bubble_cnt
    );
endinterface

// File: rtl/operand_fwd_reg.sv
// Execute-stage operand select (GRF / immediate / forwarding) with RAW-hazard stall detection,
// registered into the ID/EX boundary with hold, flush and a saturating bubble counter.
module operand_fwd_reg #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NFWD  = 2,
    parameter int CW    = 4
) (
    input logic              clk,
    input logic              reset,
    operand_fwd_reg_if.slave bus
);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    logic [WIDTH-1:0] operand_p0;
    logic [NFWD-1:0]  hit_p0;
    logic             hazard_p0;
    logic             matched;

    logic [WIDTH-1:0] op_d,   op_q;
    logic             vld_d,  vld_q;
    logic [NFWD-1:0]  hit_d,  hit_q;
    logic [CW-1:0]    cnt_d,  cnt_q;

    // Stage 0: operand resolution. Only the first address match counts, even if a later one is ready.
    always_comb begin
        operand_p0 = bus.grf_data;
        hit_p0     = '0;
        hazard_p0  = 1'b0;
        matched    = 1'b0;
        if (bus.src_sel) begin
            operand_p0 = bus.ext_data;
        end else if (bus.rs_addr != '0) begin
            for (int i = 0; i < NFWD; i++) begin
                if (!matched && bus.fwd_we[i] && (bus.fwd_addr[i*AW +: AW] == bus.rs_addr)) begin
                    matched = 1'b1;
                    if (bus.fwd_rdy[i]) begin
                        operand_p0 = bus.fwd_data[i*WIDTH +: WIDTH];
                        hit_p0[i]  = 1'b1;
                    end else begin
                        hazard_p0  = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.stall_req = bus.in_valid & hazard_p0 & ~bus.flush;

    always_comb begin
        op_d  = op_q;
        vld_d = vld_q;
        hit_d = hit_q;
        cnt_d = cnt_q;
        if (bus.flush) begin
            op_d  = '0;
            vld_d = 1'b0;
            hit_d = '0;
            cnt_d = '0;
        end else if (bus.en) begin
            if (bus.in_valid && hazard_p0) begin
                op_d  = '0;
                vld_d = 1'b0;
                hit_d = '0;
                cnt_d = sat_inc(cnt_q);
            end else begin
                op_d  = operand_p0;
                vld_d = bus.in_valid;
                hit_d = bus.in_valid ? hit_p0 : '0;
                cnt_d = '0;
            end
        end
    end

    // Stage 1: ID/EX boundary register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= '0;
            vld_q <= 1'b0;
            hit_q <= '0;
            cnt_q <= '0;
        end else begin
            op_q  <= op_d;
            vld_q <= vld_d;
            hit_q <= hit_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.op_out     = op_q;
    assign bus.op_valid   = vld_q;
    assign bus.fwd_hit    = hit_q;
    assign bus.bubble_cnt = cnt_q;

endmodule
